// File: rtl/dm_alloc_pkg.sv
// Shared types for the dm hardware allocator.
// Op codes, FSM states and the error-response address.
package dm_alloc_pkg;

  typedef enum logic {
    DM_OP_ALLOC = 1'b0,
    DM_OP_FREE  = 1'b1
  } dm_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_FREE,
    ST_RESP
  } dm_state_e;

  localparam logic [63:0] DM_ALLOC_ERR_ADDR = 64'h0;

  function automatic logic is_pow2(input logic [63:0] v);
    return (v != '0) && ((v & (v - 64'd1)) == '0);
  endfunction

endpackage

// File: rtl/dm_alloc_window.sv
// Window mask generator: size ones starting at idx.
// Flags windows that run past the end of the pool.
module dm_alloc_window #(
  parameter int NUNITS = 16
) (
  input  logic [63:0]       idx,
  input  logic [63:0]       size,
  output logic [NUNITS-1:0] mask,
  output logic              ovf
);

  logic [64:0] end_w;

  // Per-bit range compare avoids a wide barrel shift
  always_comb begin
    end_w = {1'b0, idx} + {1'b0, size};
    ovf   = end_w > 65'(NUNITS);
    mask  = '0;
    for (int i = 0; i < NUNITS; i++) begin
      mask[i] = (64'(i) >= idx) && (65'(i) < end_w);
    end
  end

endmodule

// File: rtl/dm_hw_allocator.sv
// First-fit byte-granule allocator behind valid/ready channels.
// Optional DM_ALLOC_STATS_EN adds used_bytes/peak_bytes outputs.
module dm_hw_allocator
  import dm_alloc_pkg::*;
#(
  parameter logic [63:0] BASE = 64'd1,
  parameter int          SIZE = 16,
  localparam int         NUNITS = SIZE,
  localparam int         LW = $clog2(SIZE + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_op,
  input  logic [63:0]   req_size,
  input  logic [63:0]   req_align,
  input  logic [63:0]   req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [63:0]   rsp_addr,
  output logic          rsp_err
`ifdef DM_ALLOC_STATS_EN
  ,
  output logic [LW-1:0] used_bytes,
  output logic [LW-1:0] peak_bytes
`endif
);

  localparam int          IW = (NUNITS > 1) ? $clog2(NUNITS) : 1;
  localparam logic [63:0] NEG_BASE = ~BASE + 64'd1;

  if (SIZE < 1 || SIZE > 64) begin : g_bad_size
    $error("dm_hw_allocator: SIZE out of range");
  end
  if (BASE > (64'hFFFF_FFFF_FFFF_FFFF - 64'(SIZE))) begin : g_bad_base
    $error("dm_hw_allocator: BASE+SIZE overflows");
  end

  dm_state_e state_q, state_d;

  logic [NUNITS-1:0]         used_q, used_d;
  logic [NUNITS-1:0]         start_q, start_d;
  logic [NUNITS-1:0][LW-1:0] len_q, len_d;

  logic [63:0] size_q, size_d;
  logic [63:0] align_q, align_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] idx_q, idx_d;
  logic [63:0] rsp_addr_q, rsp_addr_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rdy_q, vld_q;

  logic [63:0]       off;
  logic              off_ok;
  logic              free_ok;
  logic [IW-1:0]     off_i;
  logic [IW-1:0]     idx_i;
  logic [63:0]       free_len;
  logic              req_bad;
  logic [63:0]       win_idx;
  logic [63:0]       win_size;
  logic [NUNITS-1:0] win_mask;
  logic              win_ovf;

  // FREE target decode and window source selection
  always_comb begin
    off      = addr_q - BASE;
    off_ok   = (addr_q >= BASE) && (off < 64'(NUNITS));
    off_i    = off[IW-1:0];
    idx_i    = idx_q[IW-1:0];
    free_ok  = off_ok && start_q[off_i];
    free_len = off_ok ? 64'(len_q[off_i]) : '0;
    req_bad  = (req_size == '0) || (req_size > 64'(SIZE))
            || !is_pow2(req_align);
    win_idx  = (state_q == ST_FREE) ? off : idx_q;
    win_size = (state_q == ST_FREE) ? free_len : size_q;
  end

  dm_alloc_window #(
    .NUNITS(NUNITS)
  ) u_window (
    .idx  (win_idx),
    .size (win_size),
    .mask (win_mask),
    .ovf  (win_ovf)
  );

  // Next-state and datapath updates
  always_comb begin
    state_d    = state_q;
    used_d     = used_q;
    start_d    = start_q;
    len_d      = len_q;
    size_d     = size_q;
    align_d    = align_q;
    addr_d     = addr_q;
    idx_d      = idx_q;
    rsp_addr_d = rsp_addr_q;
    rsp_err_d  = rsp_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && rdy_q) begin
          size_d  = req_size;
          align_d = req_align;
          addr_d  = req_addr;
          if (dm_op_e'(req_op) == DM_OP_FREE) begin
            state_d = ST_FREE;
          end else if (req_bad) begin
            rsp_addr_d = DM_ALLOC_ERR_ADDR;
            rsp_err_d  = 1'b1;
            state_d    = ST_RESP;
          end else begin
            idx_d   = NEG_BASE & (req_align - 64'd1);
            state_d = ST_SCAN;
          end
        end
      end
      ST_SCAN: begin
        if (win_ovf) begin
          rsp_addr_d = DM_ALLOC_ERR_ADDR;
          rsp_err_d  = 1'b1;
          state_d    = ST_RESP;
        end else if ((used_q & win_mask) == '0) begin
          used_d         = used_q | win_mask;
          start_d[idx_i] = 1'b1;
          len_d[idx_i]   = LW'(size_q);
          rsp_addr_d     = BASE + idx_q;
          rsp_err_d      = 1'b0;
          state_d        = ST_RESP;
        end else begin
          idx_d = idx_q + align_q;
        end
      end
      ST_FREE: begin
        if (free_ok) begin
          used_d         = used_q & ~win_mask;
          start_d[off_i] = 1'b0;
        end
        rsp_addr_d = addr_q;
        rsp_err_d  = !free_ok;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, pool tables and registered handshake outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      used_q     <= '0;
      start_q    <= '0;
      len_q      <= '0;
      size_q     <= '0;
      align_q    <= '0;
      addr_q     <= '0;
      idx_q      <= '0;
      rsp_addr_q <= '0;
      rsp_err_q  <= 1'b0;
      rdy_q      <= 1'b0;
      vld_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      used_q     <= used_d;
      start_q    <= start_d;
      len_q      <= len_d;
      size_q     <= size_d;
      align_q    <= align_d;
      addr_q     <= addr_d;
      idx_q      <= idx_d;
      rsp_addr_q <= rsp_addr_d;
      rsp_err_q  <= rsp_err_d;
      rdy_q      <= (state_d == ST_IDLE);
      vld_q      <= (state_d == ST_RESP);
    end
  end

  assign req_ready = rdy_q;
  assign rsp_valid = vld_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_err   = rsp_err_q;

`ifdef DM_ALLOC_STATS_EN
  logic [LW-1:0] used_bytes_q, used_bytes_d;
  logic [LW-1:0] peak_bytes_q, peak_bytes_d;

  // Occupancy popcount and running maximum, one cycle behind the bitmap
  always_comb begin
    used_bytes_d = '0;
    for (int i = 0; i < NUNITS; i++) begin
      used_bytes_d = used_bytes_d + LW'(used_q[i]);
    end
    peak_bytes_d = (used_bytes_d > peak_bytes_q) ? used_bytes_d
                                                 : peak_bytes_q;
  end

  // Statistics registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      used_bytes_q <= '0;
      peak_bytes_q <= '0;
    end else begin
      used_bytes_q <= used_bytes_d;
      peak_bytes_q <= peak_bytes_d;
    end
  end

  assign used_bytes = used_bytes_q;
  assign peak_bytes = peak_bytes_q;
`endif

endmodule

// File: doc/dm_hw_allocator.md
Name: dm_hw_allocator

Overview:
- Hardware responder for the dm allocator request protocol: services alloc(size, align) and free(addr) requests against a fixed address pool [BASE, BASE+SIZE).
- Same semantics as the software dm allocator: 1-byte granule, first-fit, alignment applied to the absolute address.
- Sits behind a valid/ready request channel and a valid/ready response channel.
- Replaces DPI allocator calls in synthesizable memory-manager paths.

Parameters:
- BASE, 1, first address of the pool (64-bit).
- SIZE, 16, pool size in bytes; legal range 1..64; NUNITS = SIZE.
- LW, $clog2(SIZE+1), derived width of the length-table entries (localparam).

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  request accepted when valid&&ready
- req_op  input  1  0=ALLOC, 1=FREE
- req_size  input  64  ALLOC byte count
- req_align  input  64  ALLOC alignment, must be a power of two
- req_addr  input  64  FREE address
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumed when valid&&ready
- rsp_addr  output  64  ALLOC: allocated address (0 on error); FREE: echo of req_addr
- rsp_err  output  1  request failed

Behaviour:
- State: used bitmap[NUNITS], start bitmap[NUNITS], len table[NUNITS][LW].
- FSM states: IDLE, SCAN, FREE, RESP.
- Reset (async, reset_n=0): state=IDLE; bitmaps cleared; req_ready=0, rsp_valid=0, rsp_addr=0, rsp_err=0. Reset mid-operation abandons the operation with no response and frees all allocations.
- IDLE: req_ready=1. Accepting a request latches all request fields.
  - ALLOC with an illegal request goes to RESP with err=1 and addr=0. Illegal means: size==0, size>SIZE, align==0, or align not a power of two.
  - Legal ALLOC: idx = first index with (BASE+idx)%align==0, then go to SCAN.
  - FREE goes to FREE.
- SCAN: one candidate per cycle. Window mask = size ones shifted left by idx.
  - If idx+size>NUNITS: RESP with err=1.
  - Else if (used & mask)==0: set used|=mask, start[idx]=1, len[idx]=size; RESP with addr=BASE+idx, err=0.
  - Else: idx += align, stay in SCAN.
  - Latency from accept to rsp_valid = 1 + number of candidates examined.
- FREE: off = addr-BASE.
  - Error when addr<BASE, off>=NUNITS, or start[off]==0. Double free is covered by the start[off]==0 check.
  - Otherwise clear used over len[off] bits from off, clear start[off], err=0.
  - Go to RESP after 1 cycle.
- RESP: rsp_valid=1, req_ready=0. Hold rsp_addr/rsp_err stable until rsp_ready; then go to IDLE and drop rsp_valid.
  - No new request is accepted in the same cycle as the response handshake, so back-to-back throughput is at most one request per 3 cycles.
- Arithmetic: all address math is 64-bit unsigned; BASE+SIZE must not overflow (elaboration assertion).
- Alignment that exceeds the pool (no aligned index < NUNITS) returns err=1 from SCAN on its first candidate.

Optional Feature:
- Macro: DM_ALLOC_STATS_EN.
- Defined: adds outputs used_bytes [LW] (current popcount of the used bitmap) and peak_bytes [LW] (maximum used_bytes since reset). Both are registered and update the cycle after the SCAN commit or FREE clear. Both reset to 0.
- Undefined: ports and logic absent; no other behavioural change.

Decomposition:
- Shared package dm_alloc_pkg:
  - op enum (DM_OP_ALLOC, DM_OP_FREE)
  - FSM state enum
  - response-error constant DM_ALLOC_ERR_ADDR = 64'h0
- Sub-module dm_alloc_window: purely combinational.
  - Inputs: idx, size.
  - Outputs: NUNITS-bit mask and an overflow flag.
  - Used by both SCAN (test/set) and FREE (clear, with size=len[off]).

Test Plan:
- Defaults, 8 × ALLOC(size=1, align=1), rsp_ready=1 -> addresses 0x1..0x8 in order, err=0; each response 2 cycles after accept.
- Then FREE(0x1)..FREE(0x8) -> err=0 each, addr echoed; next ALLOC(16,1) -> 0x1.
- ALLOC(4,4) on an empty pool -> 0x4. Then ALLOC(4,4) -> 0x8, then ALLOC(4,4) -> 0xC. The next ALLOC(1,1) -> 0x1 and the one after -> 0x2 (first-fit below 0x4 region).
- Errors: ALLOC(17,1), ALLOC(0,1), ALLOC(1,3), ALLOC(1,32), FREE(0x0), FREE(0x11), FREE of a mid-allocation address, double FREE -> err=1 each, pool state unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_addr/rsp_err stable, req_ready=0. Assert reset_n low during SCAN -> outputs zero immediately; after release, ALLOC(1,1) -> 0x1.
- With DM_ALLOC_STATS_EN: ALLOC(3,1), ALLOC(5,1), FREE(0x1) -> used_bytes 3,8,5 and peak_bytes 3,8,8.
